ppi_bus_ctrl: RTL and testbench
===============================

# ppi_bus_ctrl

Parametrised, clocked bus-interface controller for the PPI. It synchronises the asynchronous CS/RD/WR strobes into CLK and decodes A into one-hot port selects. It runs a read/write transaction FSM and owns the control word register, including mode-set and port-C bit set/reset (BSR) decoding. It sits between the host bus pins and the port datapath blocks and generates all per-port read/write strobes.

## Interface
Parameters:
- NUM_PORTS, 3: number of data ports (2..7); port C is always index 2.
- DATA_W, 8: data bus width (≥8).
- ADDR_W, 2: address width; must satisfy 2^ADDR_W ≥ NUM_PORTS+1.
- CTRL_RST, 8'h9B: control word reset value (zero-extended to DATA_W).

Ports (clock and reset first):
- CLK  in  1  single system clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- CS  in  1  chip select, active-low, asynchronous to CLK.
- RD  in  1  read strobe, active-low, asynchronous.
- WR  in  1  write strobe, active-low, asynchronous.
- A  in  ADDR_W  register address; A==NUM_PORTS is the control register.
- D_IN  in  DATA_W  host write data.
- PORT_RDATA  in  NUM_PORTS*DATA_W  port read data, port i at slice i.
- D_OUT  out  DATA_W  registered read data.
- D_OE  out  1  host bus output enable.
- PORT_SEL  out  NUM_PORTS  one-hot selected port; 0 for control/out-of-range.
- PORT_RD  out  1  one-cycle pulse at start of a port read.
- PORT_WR  out  1  one-cycle pulse committing a port write.
- WR_DATA  out  DATA_W  data accompanying PORT_WR / MODE_SET.
- CTRL_WORD  out  DATA_W  current control word.
- MODE_SET  out  1  one-cycle pulse when the control word is loaded.
- BSR_STB  out  1  one-cycle pulse for port-C bit set/reset.
- BSR_BIT  out  3  bit index for BSR.
- BSR_VAL  out  1  value for BSR.
- BUS_ERR  out  1  sticky error flag.

## Operation
- CS, RD and WR each pass through a 2-flop synchroniser (reset value 1) to give cs_s, rd_s and wr_s.
- FSM states: IDLE, READ, WRITE, COMMIT.
- IDLE:
  - cs_s=0, rd_s=0, wr_s=1 → READ; latch A.
  - cs_s=0, wr_s=0, rd_s=1 → WRITE.
  - cs_s=0, rd_s=0, wr_s=0 → stay IDLE; set BUS_ERR.
- READ:
  - PORT_SEL decodes latched A; D_OE=1.
  - Each cycle D_OUT ← PORT_RDATA slice, or CTRL_WORD if A==NUM_PORTS, or 0 if A>NUM_PORTS (which also sets BUS_ERR).
  - rd_s=1 or cs_s=1 → IDLE.
- WRITE: wait.
  - cs_s=1 → IDLE with no commit (abort).
  - wr_s=1 → COMMIT; latch A and D_IN on this transition.
- COMMIT: one cycle, then IDLE.
  - A<NUM_PORTS: PORT_WR=1, PORT_SEL one-hot, WR_DATA=data.
  - A==NUM_PORTS with data[7]=1: CTRL_WORD←data, MODE_SET=1, WR_DATA=data, BUS_ERR cleared.
  - A==NUM_PORTS with data[7]=0: BSR_STB=1, BSR_BIT=data[3:1], BSR_VAL=data[0]; CTRL_WORD unchanged.
  - A>NUM_PORTS: no strobe; set BUS_ERR.
- BUS_ERR is cleared only by reset or MODE_SET.
- Reset values:
  - State=IDLE.
  - D_OUT=0, D_OE=0, PORT_SEL=0, PORT_RD=0, PORT_WR=0, WR_DATA=0.
  - CTRL_WORD=CTRL_RST.
  - MODE_SET=0, BSR_STB=0, BSR_BIT=0, BSR_VAL=0, BUS_ERR=0.
- Reset mid-transaction returns to IDLE immediately and drops D_OE. No strobe fires.

## Timing
- Synchroniser latency is 2 CLK; a strobe edge is seen by the FSM 2–3 CLK after the pin changes.
- Read:
  - PORT_RD is high for exactly the first READ cycle.
  - D_OE rises on READ entry.
  - D_OUT is valid from the second READ cycle and tracks PORT_RDATA with 1-cycle lag.
  - D_OE falls on the cycle returning to IDLE.
- Write: A and D_IN must be stable ≥3 CLK before WR rises. Strobes appear in the cycle after wr_s rises and last exactly 1 CLK.
- Back-to-back transactions need at least 1 IDLE cycle between them. A strobe still asserted on return to IDLE starts a new transaction only after the synchronised strobe deasserts and reasserts.

## Configuration
- PPI_BSR_EN defined: BSR decoding as above.
- PPI_BSR_EN undefined:
  - Control writes with data[7]=0 are ignored and set BUS_ERR.
  - BSR_STB, BSR_BIT and BSR_VAL are tied 0.

## Test plan
- Reset: assert RESET_N=0 mid-READ → D_OE=0, CTRL_WORD=8'h9B, all pulses 0, state IDLE.
- Port write: CS=0, A=1, D_IN=8'h5A, WR low 5 CLK then high → single PORT_WR pulse, PORT_SEL=3'b010, WR_DATA=8'h5A.
- Mode set: write 8'h80 to A=3 → MODE_SET pulse, CTRL_WORD=8'h80, BUS_ERR cleared; read A=3 → D_OUT=8'h80.
- BSR (PPI_BSR_EN): write 8'h0B to A=3 → BSR_STB pulse, BSR_BIT=5, BSR_VAL=1, CTRL_WORD unchanged.
- Port read: PORT_RDATA slice 0 = 8'hC3, RD low 6 CLK at A=0 → one PORT_RD pulse, D_OE=1, D_OUT=8'hC3 from the second READ cycle.
- Errors:
  - RD and WR low together → no strobes, BUS_ERR=1.
  - CS raised during WRITE → no PORT_WR.

Source files
------------

// File: rtl/ppi_bus_ctrl_if.sv
// ppi_bus_ctrl_if: host-bus pins and port-side strobes of the PPI bus controller
interface ppi_bus_ctrl_if #(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic CS;
  logic RD;
  logic WR;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D_IN;
  logic [NUM_PORTS*DATA_W-1:0] PORT_RDATA;
  logic [DATA_W-1:0] D_OUT;
  logic D_OE;
  logic [NUM_PORTS-1:0] PORT_SEL;
  logic PORT_RD;
  logic PORT_WR;
  logic [DATA_W-1:0] WR_DATA;
  logic [DATA_W-1:0] CTRL_WORD;
  logic MODE_SET;
  logic BSR_STB;
  logic [2:0] BSR_BIT;
  logic BSR_VAL;
  logic BUS_ERR;
  modport master (
    output CS, RD, WR, A, D_IN, PORT_RDATA,
    input D_OUT, D_OE, PORT_SEL, PORT_RD, PORT_WR, WR_DATA, CTRL_WORD,
    input MODE_SET, BSR_STB, BSR_BIT, BSR_VAL, BUS_ERR
  );
  modport slave (
    input CS, RD, WR, A, D_IN, PORT_RDATA,
    output D_OUT, D_OE, PORT_SEL, PORT_RD, PORT_WR, WR_DATA, CTRL_WORD,
    output MODE_SET, BSR_STB, BSR_BIT, BSR_VAL, BUS_ERR
  );
endinterface

// File: rtl/ppi_bus_ctrl.sv
// ppi_bus_ctrl: PPI host-bus controller (strobe sync, address decode, txn FSM, control word); PPI_BSR_EN enables port-C bit set/reset
module ppi_bus_ctrl #(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter logic [7:0] CTRL_RST = 8'h9B
) (
  input logic CLK,
  input logic RESET_N,
  ppi_bus_ctrl_if.slave bus
);
`ifdef PPI_BSR_EN
  localparam logic BSR_EN = 1'b1;
`else
  localparam logic BSR_EN = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(NUM_PORTS);
  typedef enum logic [1:0] {IDLE, READ, WRITE, COMMIT} state_t;
  state_t state_q, state_d;
  logic [1:0] cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic arm_q, arm_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] wd_q, wd_d, d_out_q, d_out_d, ctrl_q, ctrl_d;
  logic d_oe_q, d_oe_d, port_rd_q, port_rd_d, port_wr_q, port_wr_d;
  logic mode_set_q, mode_set_d, bsr_stb_q, bsr_stb_d, bsr_val_q, bsr_val_d, err_q, err_d;
  logic [2:0] bsr_bit_q, bsr_bit_d;
  logic [NUM_PORTS-1:0] sel_q, sel_d;
  logic cs_s, rd_s, wr_s, commit, is_port, is_ctrl;
  // two-flop synchronisers for the asynchronous active-low strobes
  always_comb begin
    cs_d = {cs_q[0], bus.CS};
    rd_d = {rd_q[0], bus.RD};
    wr_d = {wr_q[0], bus.WR};
    cs_s = cs_q[1];
    rd_s = rd_q[1];
    wr_s = wr_q[1];
  end
  // transaction FSM; arm requires both strobes to be seen high before a new transaction can start
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    wd_d = wd_q;
    d_out_d = d_out_q;
    arm_d = arm_q | (rd_s & wr_s);
    case (state_q)
      IDLE: if (!cs_s && arm_q && (rd_s ^ wr_s)) begin
        state_d = rd_s ? WRITE : READ;
        a_d = rd_s ? a_q : bus.A;
        arm_d = 1'b0;
      end
      READ: begin
        d_out_d = a_q == CTRL_A ? ctrl_q :
                  a_q < CTRL_A ? DATA_W'(bus.PORT_RDATA >> (DATA_W * a_q)) : '0;
        if (rd_s || cs_s) state_d = IDLE;
      end
      WRITE: if (cs_s) state_d = IDLE;
      else if (wr_s) begin
        state_d = COMMIT;
        a_d = bus.A;
        wd_d = bus.D_IN;
      end
      default: state_d = IDLE;
    endcase
  end
  // registered outputs, computed from the next state so each appears in the cycle it describes
  always_comb begin
    commit = state_q == WRITE && state_d == COMMIT;
    is_port = a_d < CTRL_A;
    is_ctrl = a_d == CTRL_A;
    port_rd_d = state_q == IDLE && state_d == READ;
    d_oe_d = state_d == READ;
    port_wr_d = commit && is_port;
    mode_set_d = commit && is_ctrl && wd_d[7];
    bsr_stb_d = BSR_EN && commit && is_ctrl && !wd_d[7];
    bsr_bit_d = bsr_stb_d ? wd_d[3:1] : bsr_bit_q;
    bsr_val_d = bsr_stb_d ? wd_d[0] : bsr_val_q;
    sel_d = (d_oe_d || port_wr_d) && is_port ? NUM_PORTS'(1) << a_d : '0;
    ctrl_d = mode_set_d ? wd_d : ctrl_q;
    err_d = mode_set_d ? 1'b0 : err_q | (state_q == IDLE && !cs_s && !rd_s && !wr_s) |
            (d_oe_d && a_d > CTRL_A) |
            (commit && (a_d > CTRL_A || (is_ctrl && !wd_d[7] && !BSR_EN)));
  end
  // state and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cs_q <= '1;
      rd_q <= '1;
      wr_q <= '1;
      arm_q <= 1'b1;
      a_q <= '0;
      wd_q <= '0;
      d_out_q <= '0;
      ctrl_q <= DATA_W'(CTRL_RST);
      d_oe_q <= 1'b0;
      port_rd_q <= 1'b0;
      port_wr_q <= 1'b0;
      mode_set_q <= 1'b0;
      bsr_stb_q <= 1'b0;
      bsr_bit_q <= '0;
      bsr_val_q <= 1'b0;
      err_q <= 1'b0;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      cs_q <= cs_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      arm_q <= arm_d;
      a_q <= a_d;
      wd_q <= wd_d;
      d_out_q <= d_out_d;
      ctrl_q <= ctrl_d;
      d_oe_q <= d_oe_d;
      port_rd_q <= port_rd_d;
      port_wr_q <= port_wr_d;
      mode_set_q <= mode_set_d;
      bsr_stb_q <= bsr_stb_d;
      bsr_bit_q <= bsr_bit_d;
      bsr_val_q <= bsr_val_d;
      err_q <= err_d;
      sel_q <= sel_d;
    end
  end
  assign bus.D_OUT = d_out_q;
  assign bus.D_OE = d_oe_q;
  assign bus.PORT_SEL = sel_q;
  assign bus.PORT_RD = port_rd_q;
  assign bus.PORT_WR = port_wr_q;
  assign bus.WR_DATA = wd_q;
  assign bus.CTRL_WORD = ctrl_q;
  assign bus.MODE_SET = mode_set_q;
  assign bus.BSR_STB = bsr_stb_q;
  assign bus.BSR_BIT = bsr_bit_q;
  assign bus.BSR_VAL = bsr_val_q;
  assign bus.BUS_ERR = err_q;
endmodule

// File: tb/tb_ppi_bus_ctrl.sv
// tb_ppi_bus_ctrl: directed and randomized host transactions checked against a transaction-level model
module tb_ppi_bus_ctrl;
`ifdef PPI_BSR_EN
  localparam bit BSR_EN = 1'b1;
`else
  localparam bit BSR_EN = 1'b0;
`endif
  logic CLK;
  logic RESET_N;
  int checks;
  int errors;
  logic [7:0] exp_ctrl;
  logic exp_err;
  int n_rd, n_wr, n_ms, n_bsr, bad_rd, oe_run;
  logic [2:0] sel_wr, sel_rd, bsr_bit_c;
  logic [7:0] wr_data_c, ms_data_c, dout2;
  logic bsr_val_c;
  ppi_bus_ctrl_if #(.NUM_PORTS(3), .DATA_W(8), .ADDR_W(2)) bus ();
  ppi_bus_ctrl #(.NUM_PORTS(3), .DATA_W(8), .ADDR_W(2), .CTRL_RST(8'h9B)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    oe_run = bus.D_OE ? oe_run + 1 : 0;
    if (bus.PORT_RD) begin
      n_rd++;
      if (oe_run != 1) bad_rd++;
    end
    if (oe_run == 1) sel_rd = bus.PORT_SEL;
    if (oe_run == 2) dout2 = bus.D_OUT;
    if (bus.PORT_WR) begin
      n_wr++;
      sel_wr = bus.PORT_SEL;
      wr_data_c = bus.WR_DATA;
    end
    if (bus.MODE_SET) begin
      n_ms++;
      ms_data_c = bus.WR_DATA;
    end
    if (bus.BSR_STB) begin
      n_bsr++;
      bsr_bit_c = bus.BSR_BIT;
      bsr_val_c = bus.BSR_VAL;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_state();
    chk("ctrl_word", bus.CTRL_WORD, exp_ctrl);
    chk("bus_err", bus.BUS_ERR, exp_err);
  endtask
  task automatic write_txn(input logic [1:0] a, input logic [7:0] d, input int lo);
    int w0, m0, b0, r0;
    bit port, ms, bsr;
    w0 = n_wr; m0 = n_ms; b0 = n_bsr; r0 = n_rd;
    @(posedge CLK); #2 bus.A = a; bus.D_IN = d; bus.CS = 1'b0;
    repeat (2) @(posedge CLK);
    #2 bus.WR = 1'b0;
    repeat (lo) @(posedge CLK);
    #2 bus.WR = 1'b1;
    repeat (5) @(posedge CLK);
    #2 bus.CS = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    port = a < 2'd3;
    ms = a == 2'd3 && d[7];
    bsr = a == 2'd3 && !d[7] && BSR_EN;
    if (ms) begin
      exp_ctrl = d;
      exp_err = 1'b0;
    end
    if (a == 2'd3 && !d[7] && !BSR_EN) exp_err = 1'b1;
    chk("wr_pulse", n_wr - w0, {31'b0, port});
    if (port) begin
      chk("wr_sel", sel_wr, 32'd1 << a);
      chk("wr_data", wr_data_c, d);
    end
    chk("ms_pulse", n_ms - m0, {31'b0, ms});
    if (ms) chk("ms_data", ms_data_c, d);
    chk("bsr_pulse", n_bsr - b0, {31'b0, bsr});
    if (bsr) begin
      chk("bsr_bit", bsr_bit_c, d[3:1]);
      chk("bsr_val", bsr_val_c, d[0]);
    end
    chk("wr_no_rd", n_rd - r0, 0);
    chk_state();
  endtask
  task automatic read_txn(input logic [1:0] a, input logic [23:0] rd, input int lo);
    int r0, b0, w0, m0;
    logic [7:0] exp_d;
    r0 = n_rd; b0 = bad_rd; w0 = n_wr; m0 = n_ms;
    @(posedge CLK); #2 bus.PORT_RDATA = rd; bus.A = a; bus.CS = 1'b0; bus.RD = 1'b0;
    repeat (lo) @(posedge CLK);
    #2 bus.RD = 1'b1;
    repeat (5) @(posedge CLK);
    #2 bus.CS = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    exp_d = a == 2'd3 ? exp_ctrl : rd[a*8 +: 8];
    chk("rd_pulse", n_rd - r0, 1);
    chk("rd_first", bad_rd - b0, 0);
    chk("rd_sel", sel_rd, a == 2'd3 ? 32'd0 : 32'd1 << a);
    chk("rd_dout", dout2, exp_d);
    chk("rd_oe_off", bus.D_OE, 0);
    chk("rd_no_wr", (n_wr - w0) + (n_ms - m0), 0);
    chk_state();
  endtask
  task automatic chk_reset_outputs();
    chk("rst_oe", bus.D_OE, 0);
    chk("rst_ctrl", bus.CTRL_WORD, 8'h9B);
    chk("rst_err", bus.BUS_ERR, 0);
    chk("rst_sel", bus.PORT_SEL, 0);
    chk("rst_dout", bus.D_OUT, 0);
    chk("rst_pulses", {bus.PORT_RD, bus.PORT_WR, bus.MODE_SET, bus.BSR_STB}, 0);
    chk("rst_wdata", bus.WR_DATA, 0);
    chk("rst_bsr", {bus.BSR_BIT, bus.BSR_VAL}, 0);
  endtask
  initial begin
    int w0, r0, m0, b0;
    bit seen;
    logic [1:0] ra;
    logic [7:0] rdat;
    bus.CS = 1'b1; bus.RD = 1'b1; bus.WR = 1'b1;
    bus.A = '0; bus.D_IN = '0; bus.PORT_RDATA = '0;
    RESET_N = 1'b0;
    exp_ctrl = 8'h9B;
    exp_err = 1'b0;
    repeat (3) @(negedge CLK);
    chk_reset_outputs();
    RESET_N = 1'b1;
    repeat (3) @(posedge CLK);
    write_txn(2'd1, 8'h5A, 5);
    w0 = n_wr; r0 = n_rd; m0 = n_ms; b0 = n_bsr;
    @(posedge CLK); #2 bus.CS = 1'b0; bus.RD = 1'b0; bus.WR = 1'b0;
    repeat (5) @(posedge CLK);
    #2 bus.RD = 1'b1; bus.WR = 1'b1; bus.CS = 1'b1;
    repeat (4) @(negedge CLK);
    exp_err = 1'b1;
    chk("both_low_strobes", (n_wr - w0) + (n_rd - r0) + (n_ms - m0) + (n_bsr - b0), 0);
    chk("both_low_oe", bus.D_OE, 0);
    chk_state();
    write_txn(2'd3, 8'h80, 5);
    read_txn(2'd3, 24'h123456, 6);
    write_txn(2'd3, 8'h0B, 5);
    read_txn(2'd0, 24'h7E81C3, 6);
    w0 = n_wr; m0 = n_ms;
    @(posedge CLK); #2 bus.A = 2'd2; bus.D_IN = 8'hA5; bus.CS = 1'b0; bus.WR = 1'b0;
    repeat (5) @(posedge CLK);
    #2 bus.CS = 1'b1;
    repeat (4) @(posedge CLK);
    #2 bus.WR = 1'b1;
    repeat (4) @(negedge CLK);
    chk("abort_no_wr", (n_wr - w0) + (n_ms - m0), 0);
    write_txn(2'd3, 8'h95, 4);
    @(posedge CLK); #2 bus.CS = 1'b0; bus.RD = 1'b0; bus.WR = 1'b0;
    repeat (5) @(posedge CLK);
    #2 bus.RD = 1'b1; bus.WR = 1'b1; bus.CS = 1'b1;
    repeat (4) @(negedge CLK);
    exp_err = 1'b1;
    chk_state();
    @(posedge CLK); #2 bus.A = 2'd1; bus.CS = 1'b0; bus.RD = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge CLK);
      seen = bus.D_OE;
    end
    chk("mid_read_oe", {31'b0, seen}, 1);
    #2 RESET_N = 1'b0;
    #1 chk_reset_outputs();
    bus.RD = 1'b1; bus.CS = 1'b1;
    repeat (3) @(posedge CLK);
    #2 RESET_N = 1'b1;
    exp_ctrl = 8'h9B;
    exp_err = 1'b0;
    repeat (2) @(negedge CLK);
    chk_state();
    chk("post_rst_oe", bus.D_OE, 0);
    for (int i = 0; i < 24; i++) begin
      ra = 2'($urandom_range(0, 3));
      rdat = 8'($urandom);
      if (ra == 2'd3 && $urandom_range(0, 1) == 1) rdat[7] = 1'b1;
      if ($urandom_range(0, 1) == 1) write_txn(ra, rdat, int'($urandom_range(4, 7)));
      else read_txn(ra, 24'($urandom), int'($urandom_range(5, 8)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
